// File: rtl/signed_divider.sv
// Multi-cycle restoring divider (IDLE -> PREP -> ITER x l -> FIX) with RISC-V divide-by-zero results.
// Define SIGNED_DIV_EN for two's-complement operands and overflow detection; otherwise unsigned only.
module signed_divider #(
    parameter int l = 16
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Signed,
    input  logic [l-1:0] Dividend,
    input  logic [l-1:0] Divisor,
    output logic         Busy,
    output logic         Done,
    output logic [l-1:0] Quotient,
    output logic [l-1:0] Remainder,
    output logic         DivByZero,
    output logic         Overflow
);

    localparam int CW = $clog2(l);
    localparam logic [CW-1:0] CNT_INIT = CW'(l - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [l-1:0]   dvd_q, dvd_d;
    logic [l-1:0]   dvs_q, dvs_d;
    logic [l:0]     rem_q, rem_d;
    logic [l-1:0]   quo_q, quo_d;
    logic           zero_q, zero_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [l-1:0]   quotient_q, quotient_d;
    logic [l-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

`ifdef SIGNED_DIV_EN
    localparam logic [l-1:0] MIN_VAL = {1'b1, {(l-1){1'b0}}};

    logic           sgn_q, sgn_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic           ovf_q, ovf_d;

    function automatic logic [l-1:0] abs_val(input logic [l-1:0] x, input logic en);
        return (en && x[l-1]) ? -x : x;
    endfunction
`else
    logic unused_signed;
    assign unused_signed = Signed;
`endif

    // One restoring step: the remainder is one bit wider than the operands so it never truncates.
    logic [l:0]   rem_sh;
    logic [l-1:0] quo_sh;
    logic         sub_ok;

    assign rem_sh = (rem_q << 1) | {{l{1'b0}}, quo_q[l-1]};
    assign quo_sh = {quo_q[l-2:0], 1'b0};
    assign sub_ok = (rem_sh >= {1'b0, dvs_q});

    always_comb begin
        // NOTE: every _d gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SIGNED_DIV_EN
        sgn_d       = sgn_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        ovf_d       = ovf_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    dvd_d   = Dividend;
                    dvs_d   = Divisor;
`ifdef SIGNED_DIV_EN
                    sgn_d   = Signed;
`endif
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                rem_d  = '0;
                zero_d = (dvs_q == '0);
                cnt_d  = CNT_INIT;
`ifdef SIGNED_DIV_EN
                quo_d  = abs_val(dvd_q, sgn_q);
                dvs_d  = abs_val(dvs_q, sgn_q);
                qneg_d = sgn_q & (dvd_q[l-1] ^ dvs_q[l-1]);
                rneg_d = sgn_q & dvd_q[l-1];
`else
                quo_d  = dvd_q;
`endif
                state_d = (dvs_q == '0) ? S_FIX : S_ITER;
            end

            S_ITER: begin
                if (sub_ok) begin
                    rem_d = rem_sh - {1'b0, dvs_q};
                    quo_d = quo_sh | {{(l-1){1'b0}}, 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = quo_sh;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
`ifdef SIGNED_DIV_EN
                    ovf_d       = 1'b0;
`endif
                end else begin
                    dbz_d       = 1'b0;
`ifdef SIGNED_DIV_EN
                    // MIN / -1: the positive magnitude 2^(l-1) is not representable.
                    quotient_d  = qneg_q ? -quo_q : quo_q;
                    remainder_d = rneg_q ? -rem_q[l-1:0] : rem_q[l-1:0];
                    ovf_d       = sgn_q & ~qneg_q & (quo_q == MIN_VAL);
`else
                    quotient_d  = quo_q;
                    remainder_d = rem_q[l-1:0];
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SIGNED_DIV_EN
            sgn_q       <= sgn_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign DivByZero = dbz_q;
`ifdef SIGNED_DIV_EN
    assign Overflow  = ovf_q;
`else
    assign Overflow  = 1'b0;
`endif

endmodule
